// File: rtl/am_iq_demod_dec.sv
// I/Q mixer + selectable envelope detector + integrate-and-dump decimator; out_valid 4 cycles
// after the last contributing input. No backpressure: every qualified input is consumed.
module am_iq_demod_dec #(
    parameter int ADC_W     = 8,
    parameter int LO_W      = 16,
    parameter int ACC_W     = 2*ADC_W+17,
    parameter int OUT_W     = 18,
    parameter int OUT_SHIFT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [ADC_W-1:0] adc_data,
    input  logic signed [LO_W-1:0]  lo_sin,
    input  logic signed [LO_W-1:0]  lo_cos,
    input  logic [1:0]              mode,
    input  logic [15:0]             dec_ratio,
    output logic signed [OUT_W-1:0] demod_out,
    output logic                    out_valid,
    output logic                    sat_flag
);
    localparam int P_W   = ADC_W + LO_W;
    localparam int DET_W = 2*ADC_W + 1;
    localparam int AB_W  = ADC_W + 1;

    localparam logic signed [P_W-1:0]   ADC_MAX = P_W'(2**(ADC_W-1) - 1);
    localparam logic signed [P_W-1:0]   ADC_MIN = ~ADC_MAX;
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'(2**(OUT_W-1) - 1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

    // Stage 1: full-precision mixer products
    logic                  v1;
    logic signed [P_W-1:0] p_i, p_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1  <= 1'b0;
            p_i <= '0;
            p_q <= '0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                p_i <= P_W'(adc_data) * P_W'(lo_cos);
                p_q <= P_W'(adc_data) * P_W'(lo_sin);
            end
        end
    end

    // Stage 2: rescale by the LO full-scale and clip back to ADC width
    logic                    v2;
    logic signed [ADC_W-1:0] i2, q2, i_nxt, q_nxt;
    logic signed [P_W-1:0]   sh_i, sh_q;

    always_comb begin
        sh_i  = p_i >>> (LO_W-1);
        sh_q  = p_q >>> (LO_W-1);
        i_nxt = sh_i[ADC_W-1:0];
        q_nxt = sh_q[ADC_W-1:0];
        if (sh_i > ADC_MAX)      i_nxt = ADC_MAX[ADC_W-1:0];
        else if (sh_i < ADC_MIN) i_nxt = ADC_MIN[ADC_W-1:0];
        if (sh_q > ADC_MAX)      q_nxt = ADC_MAX[ADC_W-1:0];
        else if (sh_q < ADC_MIN) q_nxt = ADC_MIN[ADC_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2 <= 1'b0;
            i2 <= '0;
            q2 <= '0;
        end else begin
            v2 <= v1;
            if (v1) begin
                i2 <= i_nxt;
                q2 <= q_nxt;
            end
        end
    end

    // Stage 3: detector. Frame position is tracked here so the first sample of a
    // frame already sees the freshly latched mode and ratio.
    logic                    v3, det_last, last_nxt, frame_start;
    logic signed [DET_W-1:0] det, det_nxt;
    logic [15:0]             cnt, ratio_l, ratio_use;
    logic [1:0]              mode_l, mode_use;
    logic signed [AB_W-1:0]  ie, qe, ai, aq, mx, mn;

    always_comb begin
        frame_start = (cnt == 16'd0);
        mode_use    = frame_start ? mode : mode_l;
        ratio_use   = ratio_l;
        if (frame_start) ratio_use = (dec_ratio == 16'd0) ? 16'd1 : dec_ratio;
        last_nxt    = (cnt == ratio_use - 16'd1);

        ie = AB_W'(i2);
        qe = AB_W'(q2);
        ai = ie[AB_W-1] ? -ie : ie;
        aq = qe[AB_W-1] ? -qe : qe;
        mx = (ai > aq) ? ai : aq;
        mn = (ai > aq) ? aq : ai;

        case (mode_use)
            2'd1:    det_nxt = DET_W'(mx) + (DET_W'(mn) >>> 1);
            2'd2:    det_nxt = DET_W'(i2);
            default: det_nxt = DET_W'(i2) * DET_W'(i2) + DET_W'(q2) * DET_W'(q2);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v3       <= 1'b0;
            det      <= '0;
            det_last <= 1'b0;
            cnt      <= '0;
            ratio_l  <= 16'd1;
            mode_l   <= 2'd0;
        end else begin
            v3 <= v2;
            if (v2) begin
                det      <= det_nxt;
                det_last <= last_nxt;
                cnt      <= last_nxt ? 16'd0 : cnt + 16'd1;
                if (frame_start) begin
                    mode_l  <= mode;
                    ratio_l <= ratio_use;
                end
            end
        end
    end

    // Stage 4: integrate and dump
    logic signed [ACC_W-1:0] acc, sum, sum_sh;
    logic signed [OUT_W-1:0] out_nxt;
    logic                    clip;

    always_comb begin
        sum     = acc + ACC_W'(det);
        sum_sh  = sum >>> OUT_SHIFT;
        out_nxt = sum_sh[OUT_W-1:0];
        clip    = 1'b0;
        if (sum_sh > OUT_MAX) begin
            out_nxt = OUT_MAX[OUT_W-1:0];
            clip    = 1'b1;
        end else if (sum_sh < OUT_MIN) begin
            out_nxt = OUT_MIN[OUT_W-1:0];
            clip    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            demod_out <= '0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (v3) begin
                if (det_last) begin
                    acc       <= '0;
                    demod_out <= out_nxt;
                    out_valid <= 1'b1;
                    sat_flag  <= clip;
                end else begin
                    acc <= sum;
                end
            end
        end
    end
endmodule

// File: tb/tb_am_iq_demod_dec.sv
// Bench for am_iq_demod_dec: two instances (output shift 0 and 8) share one stimulus stream;
// a frame-level reference model feeds per-instance expectation queues drained by a monitor.
module tb_am_iq_demod_dec;
    localparam int ADC_W = 8;
    localparam int LO_W  = 16;
    localparam int OUT_W = 18;
    localparam int SH_A  = 0;
    localparam int SH_B  = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic signed [ADC_W-1:0] adc_data;
    logic signed [LO_W-1:0]  lo_sin, lo_cos;
    logic [1:0]              mode;
    logic [15:0]             dec_ratio;
    logic signed [OUT_W-1:0] out_a, out_b;
    logic                    vld_a, vld_b, sat_a, sat_b;

    always #5 clk = ~clk;

    am_iq_demod_dec #(.OUT_SHIFT(SH_A)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .adc_data(adc_data),
        .lo_sin(lo_sin), .lo_cos(lo_cos), .mode(mode), .dec_ratio(dec_ratio),
        .demod_out(out_a), .out_valid(vld_a), .sat_flag(sat_a)
    );

    am_iq_demod_dec #(.OUT_SHIFT(SH_B)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .adc_data(adc_data),
        .lo_sin(lo_sin), .lo_cos(lo_cos), .mode(mode), .dec_ratio(dec_ratio),
        .demod_out(out_b), .out_valid(vld_b), .sat_flag(sat_b)
    );

    typedef struct {
        longint val;
        bit     sat;
        int     cyc;
    } exp_t;

    exp_t   q_a[$];
    exp_t   q_b[$];
    int     cyc = 0;
    int     compared = 0;
    int     mismatched = 0;
    bit     mon_en = 1'b0;
    longint hold_val[2];
    bit     hold_sat[2];

    // frame-level model state
    longint m_acc;
    int     m_cnt;
    int     m_ratio;
    int     m_mode;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint sat_w(input longint x, input int w);
        longint hi, lo;
        hi = (longint'(1) <<< (w-1)) - 1;
        lo = -hi - 1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    function automatic longint model_det(input longint a, input longint c, input longint s, input int md);
        longint i, q, ai, aq, mx, mn;
        i  = sat_w((a * c) >>> (LO_W-1), ADC_W);
        q  = sat_w((a * s) >>> (LO_W-1), ADC_W);
        ai = (i < 0) ? -i : i;
        aq = (q < 0) ? -q : q;
        mx = (ai > aq) ? ai : aq;
        mn = (ai > aq) ? aq : ai;
        case (md)
            1:       return mx + (mn >>> 1);
            2:       return i;
            default: return i*i + q*q;
        endcase
    endfunction

    function automatic exp_t make_exp(input longint s, input int sh, input int at);
        exp_t   e;
        longint shifted;
        shifted = s >>> sh;
        e.val   = sat_w(shifted, OUT_W);
        e.sat   = (e.val != shifted);
        e.cyc   = at;
        return e;
    endfunction

    task automatic model_sample(input int a, input int c, input int s);
        if (m_cnt == 0) begin
            m_ratio = (dec_ratio == 16'd0) ? 1 : int'(dec_ratio);
            m_mode  = int'(mode);
        end
        m_acc += model_det(longint'(a), longint'(c), longint'(s), m_mode);
        m_cnt++;
        if (m_cnt == m_ratio) begin
            q_a.push_back(make_exp(m_acc, SH_A, cyc + 4));
            q_b.push_back(make_exp(m_acc, SH_B, cyc + 4));
            m_acc = 0;
            m_cnt = 0;
        end
    endtask

    task automatic drive(input bit v, input int a, input int c, input int s);
        in_valid = v;
        adc_data = a[ADC_W-1:0];
        lo_cos   = c[LO_W-1:0];
        lo_sin   = s[LO_W-1:0];
        if (v) model_sample(a, c, s);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 0);
    endtask

    task automatic check_zero(input string name);
        compared++;
        if (out_a !== '0 || vld_a !== 1'b0 || sat_a !== 1'b0 ||
            out_b !== '0 || vld_b !== 1'b0 || sat_b !== 1'b0) begin
            mismatched++;
            $display("FAIL %s: got a=%0d/%b/%b b=%0d/%b/%b, required all zero",
                     name, out_a, vld_a, sat_a, out_b, vld_b, sat_b);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        m_acc = 0;
        m_cnt = 0;
        for (int k = 0; k < 2; k++) begin
            hold_val[k] = 0;
            hold_sat[k] = 1'b0;
        end
    endtask

    task automatic check_one(input int k, input logic v, input logic signed [OUT_W-1:0] d, input logic s);
        exp_t e;
        bit   empty;
        empty = (k == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
        compared++;
        if (v === 1'b1) begin
            if (empty) begin
                mismatched++;
                $display("FAIL unexpected_out[%0d] cyc=%0d: got val=%0d, required no output", k, cyc, d);
            end else begin
                e = (k == 0) ? q_a.pop_front() : q_b.pop_front();
                if (longint'(d) !== e.val || s !== e.sat || cyc != e.cyc) begin
                    mismatched++;
                    $display("FAIL out[%0d]: got val=%0d sat=%0d cyc=%0d, required val=%0d sat=%0d cyc=%0d",
                             k, d, s, cyc, e.val, e.sat, e.cyc);
                end
                hold_val[k] = e.val;
                hold_sat[k] = e.sat;
            end
        end else if (v !== 1'b0 || longint'(d) !== hold_val[k] || s !== hold_sat[k]) begin
            mismatched++;
            $display("FAIL hold[%0d] cyc=%0d: got vld=%b val=%0d sat=%b, required vld=0 val=%0d sat=%0d",
                     k, cyc, v, d, s, hold_val[k], hold_sat[k]);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check_one(0, vld_a, out_a, sat_a);
            check_one(1, vld_b, out_b, sat_b);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int n, r, a, c, s;
        bit v;
        rst = 1'b1; in_valid = 1'b0; adc_data = '0; lo_sin = '0; lo_cos = '0;
        mode = 2'd0; dec_ratio = 16'd1;
        m_acc = 0; m_cnt = 0; m_ratio = 1; m_mode = 0;
        hold_val[0] = 0; hold_val[1] = 0; hold_sat[0] = 1'b0; hold_sat[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero("reset_state");
        mon_en = 1'b1;

        // square-law, ratio 4: 4*3969 per frame
        mode = 2'd0; dec_ratio = 16'd4;
        repeat (12) drive(1'b1, 64, 32767, 0);
        idle(6);

        // magnitude approx, then a mode/ratio change in the middle of a frame
        mode = 2'd1;
        repeat (8) drive(1'b1, 64, 32767, 0);
        repeat (2) drive(1'b1, 64, 32767, 32767);
        idle(6);
        mode = 2'd2; dec_ratio = 16'd3;
        repeat (2) drive(1'b1, 64, 32767, 32767);
        repeat (6) drive(1'b1, 64, 32767, 32767);
        idle(6);
        dec_ratio = 16'd4;
        repeat (4) drive(1'b1, 64, 32767, 0);
        idle(6);

        // stage-2 clipping and output saturation, positive and negative
        mode = 2'd0; dec_ratio = 16'd5;
        repeat (5) drive(1'b1, -128, -32768, -32768);
        idle(6);
        dec_ratio = 16'd1100;
        repeat (1100) drive(1'b1, -128, -32768, -32768);
        idle(6);
        mode = 2'd2;
        repeat (1100) drive(1'b1, -128, 32767, 0);
        idle(6);

        // ratio 0 and 1 with bubbles between samples
        mode = 2'd0;
        dec_ratio = 16'd0;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, int'($urandom_range(0, 255)) - 128, 32767, 12000);
            drive(1'b0, 0, 0, 0);
        end
        idle(6);
        dec_ratio = 16'd1;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, int'($urandom_range(0, 255)) - 128, -20000, 32767);
            drive(1'b0, 0, 0, 0);
        end
        idle(6);

        // reset in the middle of a frame of 8
        dec_ratio = 16'd8;
        repeat (5) drive(1'b1, 64, 32767, 0);
        do_reset();
        check_zero("mid_frame_reset");
        repeat (8) drive(1'b1, 64, 32767, 0);
        idle(6);

        // coherent I with a negative sample
        mode = 2'd2; dec_ratio = 16'd2;
        repeat (4) drive(1'b1, -64, 32767, 0);
        idle(6);

        // randomized segments; config changes only while the pipeline is empty
        for (int seg = 0; seg < 40; seg++) begin
            idle(5);
            mode = 2'($urandom_range(0, 3));
            r = int'($urandom_range(0, 9));
            if (r == 0)     dec_ratio = 16'd0;
            else if (r < 7) dec_ratio = 16'($urandom_range(1, 8));
            else            dec_ratio = 16'($urandom_range(9, 40));
            n = int'($urandom_range(5, 60));
            for (int k = 0; k < n; k++) begin
                v = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0) begin
                    a = -128; c = -32768; s = ($urandom_range(0, 1) != 0) ? -32768 : 32767;
                end else begin
                    a = int'($urandom_range(0, 255)) - 128;
                    c = int'($urandom_range(0, 65535)) - 32768;
                    s = int'($urandom_range(0, 65535)) - 32768;
                end
                drive(v, a, c, s);
            end
        end
        idle(10);

        compared++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d/%0d outputs still pending, required 0/0", q_a.size(), q_b.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/am_iq_demod_dec.md
Name: am_iq_demod_dec

Overview:
- Parametrised successor of the fixed 8-bit AM demodulator.
- Mixes a signed ADC stream with externally supplied LO sine/cosine samples to I/Q, then applies a runtime-selectable envelope detector: square-law, magnitude approximation or coherent-I.
- Decimates with a runtime-programmable integrate-and-dump stage and delivers a saturated output sample with a one-cycle valid strobe.
- Sits between the LO/ADC front end and the post-decimation FIR.

Parameters:
- ADC_W, 8, ADC sample width (signed).
- LO_W, 16, LO sine/cosine width (signed).
- ACC_W, 2*ADC_W+17, accumulator width (signed).
- OUT_W, 18, output width (signed).
- OUT_SHIFT, 8, arithmetic right shift applied to the dumped sum before saturation.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  qualifies adc_data/lo_sin/lo_cos this cycle.
- adc_data  in  ADC_W  signed ADC sample.
- lo_sin  in  LO_W  signed LO sine.
- lo_cos  in  LO_W  signed LO cosine.
- mode  in  2  detector select: 0 square-law, 1 magnitude approx, 2 coherent I, 3 treated as 0.
- dec_ratio  in  16  samples per output; 0 treated as 1.
- demod_out  out  OUT_W  signed decimated output.
- out_valid  out  1  one-cycle pulse when demod_out updates.
- sat_flag  out  1  high with out_valid when that output saturated.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. All pipeline registers, valids, accumulator and sample counter clear. demod_out=0, out_valid=0, sat_flag=0. Reset mid-frame discards the partial sum; the first frame after reset starts at the first valid detector sample.
- Stage 1 (t+1): pI=adc_data*lo_cos, pQ=adc_data*lo_sin, each full precision ADC_W+LO_W signed. The valid bit advances with the data.
- Stage 2 (t+2): I=pI>>>(LO_W-1), Q=pQ>>>(LO_W-1) (arithmetic shift, floor), saturated to ADC_W. Example: -128*-32768 gives 128, saturated to 127.
- Stage 3 (t+3): det, DET_W=2*ADC_W+1, signed.
  - mode 0: I*I+Q*Q.
  - mode 1: max(|I|,|Q|)+(min(|I|,|Q|)>>1), with abs computed in ADC_W+1 bits.
  - mode 2: I sign-extended.
- Invalid cycles: stages hold their data; only the valid bits propagate. Bubbles are allowed anywhere.
- Decimator: 16-bit counter cnt and ACC_W accumulator acc count valid det samples only.
  - Frame start (cnt==0): latch ratio_l = max(dec_ratio,1) and mode_l.
  - Stage 3 always uses mode_l. mode and dec_ratio changes take effect at the next frame boundary, never mid-frame.
  - On det_valid with cnt<ratio_l-1: acc+=det, cnt++.
  - On det_valid with cnt==ratio_l-1: sum=acc+det; acc<=0, cnt<=0; demod_out<=sat(sum>>>OUT_SHIFT, OUT_W); out_valid<=1; sat_flag<=1 if clipped, else 0.
  - Saturation limits: +2^(OUT_W-1)-1 / -2^(OUT_W-1).
- Latency: last contributing in_valid at t gives out_valid at t+4, with no bubbles.
- ratio_l=1: every valid input produces an output, giving sustained one output per valid input.
- out_valid is high for exactly one cycle per frame. demod_out and sat_flag hold their values between pulses.
- Before the first mode latch (first frame after reset), mode_l is taken from mode on the first valid det cycle.
- The accumulator never wraps for dec_ratio≤65535 at the default widths.

Test Plan:
1. Reset, mode=0, dec_ratio=4, OUT_SHIFT=0 override; adc=64, cos=32767, sin=0, in_valid continuous.
   -> I=63, Q=0, det=3969; first out_valid 7 cycles after first in_valid with demod_out=15876, sat_flag=0.
   -> Repeats every 4 cycles.
2. As 1 but mode=1, then mode=2.
   -> demod_out=252 in both cases.
   -> A mode change issued mid-frame first affects the frame after the current one.
3. adc=-128, cos=-32768, sin=-32768, mode=0, dec_ratio=65535, defaults.
   -> I=Q=127 (stage-2 saturation), det=32258, sum=2114028030.
   -> demod_out=131071, sat_flag=1.
4. dec_ratio=0 then 1, in_valid toggling 1,0,1,0.
   -> One out_valid per valid input, 4 cycles after it.
   -> Bubbles do not produce extra outputs.
5. Frame of 8 running; assert rst for 1 cycle after 5 samples.
   -> Outputs are 0 and acc is cleared.
   -> The next out_valid comes only after 8 fresh valid samples, with value 8*det.
6. adc=-64, cos=32767, sin=0, mode=2, dec_ratio=2, OUT_SHIFT=0.
   -> I=-64, demod_out=-128 (sign preserved), sat_flag=0.
